// File: rtl/tsi_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tsi_target
//  Purpose  : Chip-side TSI responder. Parses the 32-bit host word stream
//             (cmd, addr_lo, addr_hi, len_lo, len_hi, [write data]) and turns
//             it into single-word memory read/write requests, returning read
//             data on tsi_out.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock           in   single clock, rising edge
//    reset           in   asynchronous, active-low reset
//    tsi_in_*        in   host command/data stream (valid/ready/bits)
//    tsi_out_*       out  read data back to host (valid/ready/bits)
//    mem_req_*       out  word memory request (valid/ready/write/addr/wdata)
//    mem_resp_*      in   read response (valid/ready/rdata)
//    err             out  sticky protocol error flag
//    busy            out  high whenever not waiting for a command word
// ============================================================================
module tsi_target #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tsi_in_valid,
  output logic              tsi_in_ready,
  input  logic [31:0]       tsi_in_bits,
  output logic              tsi_out_valid,
  input  logic              tsi_out_ready,
  output logic [31:0]       tsi_out_bits,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  input  logic              mem_resp_valid,
  output logic              mem_resp_ready,
  input  logic [31:0]       mem_resp_rdata,
  output logic              err,
  output logic              busy
);

  typedef enum logic [3:0] {
    S_CMD     = 4'd0,
    S_ADDR_LO = 4'd1,
    S_ADDR_HI = 4'd2,
    S_LEN_LO  = 4'd3,
    S_LEN_HI  = 4'd4,
    S_WDATA   = 4'd5,
    S_WREQ    = 4'd6,
    S_RREQ    = 4'd7,
    S_RRESP   = 4'd8,
    S_RSEND   = 4'd9
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              in_rdy;
  logic [ADDR_W-1:0] addr_hi_merge;

  // Upper address word only matters when the address is wider than 32 bits;
  // otherwise addr_hi is accepted and thrown away.
  generate
    if (ADDR_W > 32) begin : g_wide_addr
      assign addr_hi_merge = {tsi_in_bits[ADDR_W-33:0], addr_q[31:0]};
    end else begin : g_narrow_addr
      assign addr_hi_merge = addr_q;
    end
  endgenerate

  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    addr_d         = addr_q;
    cnt_d          = cnt_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    in_rdy         = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_write  = 1'b0;
    mem_resp_ready = 1'b0;
    tsi_out_valid  = 1'b0;

    case (state_q)
      S_CMD: begin
        in_rdy = 1'b1;
        if (tsi_in_valid) begin
          cmd_d   = tsi_in_bits;
          state_d = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        in_rdy = 1'b1;
        if (tsi_in_valid) begin
          addr_d  = ADDR_W'(tsi_in_bits);
          state_d = S_ADDR_HI;
        end
      end
      S_ADDR_HI: begin
        in_rdy = 1'b1;
        if (tsi_in_valid) begin
          addr_d  = addr_hi_merge;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        in_rdy = 1'b1;
        if (tsi_in_valid) begin
          cnt_d   = LEN_W'(tsi_in_bits);
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        in_rdy = 1'b1;
        if (tsi_in_valid) begin
          // Oversized length or unknown command aborts the frame silently.
          if (tsi_in_bits != 32'd0 || cmd_q > 32'd1) begin
            err_d   = 1'b1;
            state_d = S_CMD;
          end else if (cmd_q == 32'd1) begin
            state_d = S_WDATA;
          end else begin
            state_d = S_RREQ;
          end
        end
      end
      S_WDATA: begin
        in_rdy = 1'b1;
        if (tsi_in_valid) begin
          wdata_d = tsi_in_bits;
          state_d = S_WREQ;
        end
      end
      S_WREQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        if (mem_req_ready) begin
          addr_d  = addr_q + ADDR_W'(4);
          cnt_d   = cnt_q - LEN_W'(1);
          state_d = (cnt_q == '0) ? S_CMD : S_WDATA;
        end
      end
      S_RREQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = S_RRESP;
        end
      end
      S_RRESP: begin
        mem_resp_ready = 1'b1;
        if (mem_resp_valid) begin
          rdata_d = mem_resp_rdata;
          state_d = S_RSEND;
        end
      end
      S_RSEND: begin
        tsi_out_valid = 1'b1;
        if (tsi_out_ready) begin
          addr_d  = addr_q + ADDR_W'(4);
          cnt_d   = cnt_q - LEN_W'(1);
          state_d = (cnt_q == '0) ? S_CMD : S_RREQ;
        end
      end
      default: begin
        state_d = S_CMD;
      end
    endcase

    // A response nobody asked for is a protocol violation.
    if (mem_resp_valid && state_q != S_RRESP) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_CMD;
      cmd_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // CMD is the reset state but must not advertise ready while reset is held,
  // so the ready is qualified by the reset pin itself.
  assign tsi_in_ready  = in_rdy & reset;
  assign tsi_out_bits  = rdata_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign err           = err_q;
  assign busy          = (state_q != S_CMD);

endmodule
`default_nettype wire
